ram_stream_reader: RTL and testbench

- Read-side controller for the team's simple dual-port RAM.
- Accepts a (start address, length) command and drives the RAM read port (ENB/ADDRB/DOB, 1-cycle latency).
- Emits the words as a valid/ready stream with LAST and a DONE pulse.
- Sits in the CLKB domain between the RAM and downstream consumers, which may apply backpressure.

---
 rtl/ram_stream_reader_pkg.sv | 21 ++
 rtl/ram_stream_reader_fifo2.sv | 63 ++++++
 rtl/ram_stream_reader.sv | 153 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and sizing helpers for the RAM stream reader.
// Optional STALL_CNT port: RAM_STREAM_READER_STALL_CNT_EN.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;

  function automatic int addr_w(input int mem_size);
    return (mem_size > 1) ? $clog2(mem_size) : 1;
  endfunction

  function automatic int len_w(input int mem_size);
    return addr_w(mem_size) + 1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_fifo2.sv
// Two-entry synchronous FIFO with a registered head word.
// Head is always presented on dout; count says how many are valid.
module ram_stream_reader_fifo2 #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] din,
  output logic [1:0]           count,
  output logic [DATA_SIZE-1:0] dout
);

  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] tail_q, tail_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 do_push, do_pop;

  always_comb begin
    do_push = push && ((cnt_q != 2'd2) || pop);
    do_pop  = pop && (cnt_q != 2'd0);
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    unique case ({do_push, do_pop})
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = din;
        end else begin
          head_d = din;
        end
      end
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din;
        else               tail_d = din;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign dout  = head_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams (addr, len) bursts out of the RAM read port as valid/ready.
// Define RAM_STREAM_READER_STALL_CNT_EN to add the STALL_CNT output.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        CMD_VALID,
  output logic                        CMD_READY,
  input  logic [addr_w(MEM_SIZE)-1:0] CMD_ADDR,
  input  logic [len_w(MEM_SIZE)-1:0]  CMD_LEN,
  output logic                        ENB,
  output logic [addr_w(MEM_SIZE)-1:0] ADDRB,
  input  logic [DATA_SIZE-1:0]        DOB,
  output logic                        M_VALID,
  input  logic                        M_READY,
  output logic [DATA_SIZE-1:0]        M_DATA,
  output logic                        M_LAST,
  output logic                        BUSY,
  output logic                        DONE
`ifdef RAM_STREAM_READER_STALL_CNT_EN
  ,
  output logic [31:0]                 STALL_CNT
`endif
);

  localparam int AW = addr_w(MEM_SIZE);
  localparam int LW = len_w(MEM_SIZE);
  localparam logic [AW-1:0] ADDR_MAX = AW'(MEM_SIZE - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MEM_SIZE);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] issue_q, issue_d;
  logic [LW-1:0] out_q, out_d;
  logic          inflight_q, inflight_d;
  logic          done_q, done_d;
  logic          init_q;
  logic [1:0]    fifo_cnt;
  logic [1:0]    occ;
  logic [LW-1:0] len_sat;
  logic          accept, pop, last_hs;

  always_comb begin
    len_sat   = (CMD_LEN > LEN_MAX) ? LEN_MAX : CMD_LEN;
    CMD_READY = init_q && (state_q == ST_IDLE);
    accept    = CMD_VALID && CMD_READY;
    M_VALID   = (fifo_cnt != 2'd0);
    pop       = M_VALID && M_READY;
    M_LAST    = M_VALID && (out_q == LW'(1));
    last_hs   = pop && M_LAST;
    // words the FIFO must still absorb once this cycle's pop retires
    occ       = fifo_cnt + 2'(inflight_q) - 2'(pop);
    ENB       = (issue_q != '0) && (occ < 2'(FIFO_DEPTH));
    ADDRB     = addr_q;
    BUSY      = (state_q != ST_IDLE);
    DONE      = done_q;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    out_d      = out_q;
    inflight_d = ENB;
    done_d     = 1'b0;
    if (ENB) begin
      addr_d  = (addr_q == ADDR_MAX) ? '0 : addr_q + AW'(1);
      issue_d = issue_q - LW'(1);
    end
    if (pop) out_d = out_q - LW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (len_sat == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_READ;
            addr_d  = CMD_ADDR;
            issue_d = len_sat;
            out_d   = len_sat;
          end
        end
      end
      ST_READ: begin
        if (issue_d == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      out_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      out_q      <= out_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      init_q     <= 1'b1;
    end
  end

  ram_stream_reader_fifo2 #(
    .DATA_SIZE(DATA_SIZE)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (inflight_q),
    .pop   (pop),
    .din   (DOB),
    .count (fifo_cnt),
    .dout  (M_DATA)
  );

`ifdef RAM_STREAM_READER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if (M_VALID && !M_READY && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader with a behavioural dual-port RAM.
// Stall counter checks need RAM_STREAM_READER_STALL_CNT_EN.
module tb_ram_stream_reader;

  localparam int DW = 64;
  localparam int MS = 1024;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [LW-1:0] CMD_LEN = '0;
  logic          ENB;
  logic [AW-1:0] ADDRB;
  logic [DW-1:0] DOB;
  logic          M_VALID;
  logic          M_READY = 1'b0;
  logic [DW-1:0] M_DATA;
  logic          M_LAST, BUSY, DONE;
`ifdef RAM_STREAM_READER_STALL_CNT_EN
  logic [31:0]   STALL_CNT;
`endif

  logic          WEA = 1'b0;
  logic [AW-1:0] ADDRA = '0;
  logic [DW-1:0] DIA = '0;
  logic [DW-1:0] ram [MS];

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (WEA) ram[ADDRA] <= DIA;
    if (ENB) DOB <= ram[ADDRB];
  end

  ram_stream_reader #(.DATA_SIZE(DW), .MEM_SIZE(MS)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .ENB(ENB), .ADDRB(ADDRB), .DOB(DOB),
    .M_VALID(M_VALID), .M_READY(M_READY),
    .M_DATA(M_DATA), .M_LAST(M_LAST),
    .BUSY(BUSY), .DONE(DONE)
`ifdef RAM_STREAM_READER_STALL_CNT_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [DW-1:0] got_q[$];
  bit            last_q[$];
  logic [AW-1:0] adr_q[$];
  int issued, popped, acc_cyc, first_enb, first_val, last_beat;
  int done_cyc, done_cnt, stab_err, full_err;
  bit done_rdy, done_busy, prev_stall, prev_last;
  logic [DW-1:0] prev_data;
  logic [31:0] done_stall;

  int rmode = 0;
  int rph = 0;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(posedge CLK);
    #1;
    case (rmode)
      0: M_READY = 1'b1;
      1: begin M_READY = (rph % 3 == 0); rph++; end
      2: M_READY = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!M_VALID || M_DATA !== prev_data ||
                         M_LAST !== prev_last)) stab_err++;
      if (CMD_VALID && CMD_READY) acc_cyc = cyc;
      if (ENB) begin
        if (issued - popped - int'(M_VALID && M_READY) >= 2) full_err++;
        if (first_enb < 0) first_enb = cyc;
        adr_q.push_back(ADDRB);
        issued++;
      end
      if (M_VALID && first_val < 0) first_val = cyc;
      if (M_VALID && M_READY) begin
        got_q.push_back(M_DATA);
        last_q.push_back(M_LAST);
        last_beat = cyc;
        popped++;
      end
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
        done_rdy = CMD_READY;
        done_busy = BUSY;
`ifdef RAM_STREAM_READER_STALL_CNT_EN
        done_stall = STALL_CNT;
`endif
      end
      prev_stall = M_VALID && !M_READY;
      prev_data = M_DATA;
      prev_last = M_LAST;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    adr_q.delete();
    issued = 0; popped = 0; acc_cyc = -100;
    first_enb = -1; first_val = -1; last_beat = -1;
    done_cyc = -1; done_cnt = 0; stab_err = 0; full_err = 0;
    done_rdy = 1'b0; done_busy = 1'b1; done_stall = 32'hDEAD;
  endtask

  task automatic send(input int a, input int l);
    int t;
    clear_mon();
    @(posedge CLK); #1;
    t = 0;
    while (!CMD_READY && t < 50) begin
      @(posedge CLK); #1;
      t++;
    end
    check("cmd_ready_wait", 64'(CMD_READY), 64'd1);
    CMD_VALID = 1'b1;
    CMD_ADDR = AW'(a);
    CMD_LEN = LW'(l);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t;
    t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check({tag, ":done_seen"}, 64'(done_cnt > 0), 64'd1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_cmd(input string tag, input int a, input int l,
                           input bit nobub);
    int ls, bad_d, bad_l, bad_a;
    ls = (l > MS) ? MS : l;
    bad_d = 0; bad_l = 0; bad_a = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] !== 64'hA000 + 64'((a + i) % MS)) bad_d++;
      if (last_q[i] !== (i == ls - 1)) bad_l++;
    end
    for (int i = 0; i < adr_q.size(); i++)
      if (adr_q[i] !== AW'((a + i) % MS)) bad_a++;
    check({tag, ":beats"}, 64'(got_q.size()), 64'(ls));
    check({tag, ":data_bad"}, 64'(bad_d), 64'd0);
    check({tag, ":last_bad"}, 64'(bad_l), 64'd0);
    check({tag, ":enb_cnt"}, 64'(adr_q.size()), 64'(ls));
    check({tag, ":addrb_bad"}, 64'(bad_a), 64'd0);
    check({tag, ":stable_err"}, 64'(stab_err), 64'd0);
    check({tag, ":full_err"}, 64'(full_err), 64'd0);
    check({tag, ":done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, ":done_ready"}, 64'(done_rdy), 64'd1);
    check({tag, ":done_busy"}, 64'(done_busy), 64'd0);
    if (ls == 0) begin
      check({tag, ":no_enb"}, 64'(first_enb), 64'(-1));
      check({tag, ":no_valid"}, 64'(first_val), 64'(-1));
      check({tag, ":done_cyc"}, 64'(done_cyc), 64'(acc_cyc + 1));
    end else begin
      check({tag, ":enb_lat"}, 64'(first_enb), 64'(acc_cyc + 1));
      check({tag, ":valid_lat"}, 64'(first_val), 64'(acc_cyc + 3));
      check({tag, ":done_cyc"}, 64'(done_cyc), 64'(last_beat + 1));
      if (nobub)
        check({tag, ":no_bubble"}, 64'(last_beat - first_val), 64'(ls - 1));
    end
  endtask

  initial begin
    int a, l, ls, t;
    clear_mon();
    #3;
    check("rst:flags", {58'd0, CMD_READY, ENB, M_VALID, M_LAST, BUSY, DONE},
          64'd0);
    check("rst:addrb", 64'(ADDRB), 64'd0);
    check("rst:mdata", M_DATA, 64'd0);
    for (int i = 0; i < MS; i++) begin
      @(posedge CLK); #1;
      WEA = 1'b1;
      ADDRA = AW'(i);
      DIA = 64'hA000 + 64'(i);
    end
    @(posedge CLK); #1;
    WEA = 1'b0;
    check("rst:held_flags", {59'd0, CMD_READY, ENB, M_VALID, BUSY, DONE},
          64'd0);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    check("post_rst:cmd_ready", 64'(CMD_READY), 64'd1);
    check("post_rst:busy", 64'(BUSY), 64'd0);

    rmode = 0;
    send(10, 4);
    wait_done("basic", 60);
    check_cmd("basic", 10, 4, 1'b1);

    send(1022, 4);
    wait_done("wrap", 60);
    check_cmd("wrap", 1022, 4, 1'b1);

    rph = 0;
    rmode = 1;
    send(0, 8);
    wait_done("bp", 100);
    check_cmd("bp", 0, 8, 1'b0);

    rmode = 0;
    send(500, 0);
    wait_done("zero", 20);
    check_cmd("zero", 500, 0, 1'b0);

    send(0, 2000);
    wait_done("over", 4 * MS + 60);
    check_cmd("over", 0, 2000, 1'b1);

    send(200, 16);
    t = 0;
    while (got_q.size() < 3 && t < 60) begin
      @(negedge CLK);
      t++;
    end
    check("mid_rst:beat3", 64'(got_q.size()), 64'd3);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst:flags", {58'd0, CMD_READY, ENB, M_VALID, M_LAST, BUSY,
          DONE}, 64'd0);
    check("mid_rst:addrb", 64'(ADDRB), 64'd0);
    check("mid_rst:mdata", M_DATA, 64'd0);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    send(100, 2);
    wait_done("after_rst", 60);
    check_cmd("after_rst", 100, 2, 1'b1);

    rmode = 2;
    for (int k = 0; k < 10; k++) begin
      a = $urandom_range(0, MS - 1);
      l = (k == 9) ? $urandom_range(MS + 1, 2047) : $urandom_range(0, 40);
      ls = (l > MS) ? MS : l;
      send(a, l);
      wait_done($sformatf("rnd%0d", k), 8 * ls + 60);
      check_cmd($sformatf("rnd%0d", k), a, l, 1'b0);
    end

`ifdef RAM_STREAM_READER_STALL_CNT_EN
    rmode = 3;
    M_READY = 1'b0;
    send(300, 4);
    t = 0;
    while (!M_VALID && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("stall:valid_seen", 64'(M_VALID), 64'd1);
    repeat (4) @(posedge CLK);
    @(posedge CLK); #1;
    M_READY = 1'b1;
    wait_done("stall", 60);
    check_cmd("stall", 300, 4, 1'b0);
    check("stall:cnt_at_done", 64'(done_stall), 64'd5);
    send(0, 0);
    wait_done("stall_clr", 20);
    check("stall:cleared", 64'(done_stall), 64'd0);
    rmode = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
